// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared FSM state encoding and default widths for mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEF_CORE_COUNT = 4;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Core request channels plus the shared data-RAM port.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int CORE_COUNT = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
);
    logic [CORE_COUNT-1:0]            req;
    logic [CORE_COUNT-1:0]            wrEn;
    logic [CORE_COUNT*ADDR_WIDTH-1:0] addr;
    logic [CORE_COUNT*DATA_WIDTH-1:0] dataIn;
    logic [CORE_COUNT-1:0]            ack;
    logic [DATA_WIDTH-1:0]            dataOut;
    logic                             ramWrEn;
    logic [ADDR_WIDTH-1:0]            ramAddr;
    logic [DATA_WIDTH-1:0]            ramDataIn;
    logic [DATA_WIDTH-1:0]            ramDataOut;

    // master: cores and RAM as seen by the environment; slave: the arbiter
    modport master (
        output req, wrEn, addr, dataIn, ramDataOut,
        input  ack, dataOut, ramWrEn, ramAddr, ramDataIn
    );

    modport slave (
        input  req, wrEn, addr, dataIn, ramDataOut,
        output ack, dataOut, ramWrEn, ramAddr, ramDataIn
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Brief    : Combinational round-robin pick starting after the last grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int CORE_COUNT = 4,
    parameter int IDX_WIDTH  = $clog2(CORE_COUNT)
) (
    input  logic [CORE_COUNT-1:0] eligible_i,
    input  logic [IDX_WIDTH-1:0]  last_grant_i,
    output logic                  valid_o,
    output logic [IDX_WIDTH-1:0]  grant_o
);

    int idx;

    // Walk from the farthest offset to the nearest so the nearest match wins.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        idx     = 0;
        for (int k = CORE_COUNT; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % CORE_COUNT;
            if (eligible_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx[IDX_WIDTH-1:0];
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Round-robin arbiter of per-core requests onto one data-RAM port.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CORE_COUNT = DEF_CORE_COUNT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int IDX_WIDTH  = $clog2(CORE_COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave mem_if
);

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0]    last_grant_q, last_grant_d;
    logic [CORE_COUNT-1:0]   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_data_in_q, ram_data_in_d;

    logic [CORE_COUNT-1:0]   w_eligible;
    logic                    w_pick_valid;
    logic [IDX_WIDTH-1:0]    w_pick_idx;

    // A core being acked this cycle must not be re-granted on its stale req.
    assign w_eligible = mem_if.req & ~ack_q;

    rr_picker #(
        .CORE_COUNT (CORE_COUNT),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_picker (
        .eligible_i   (w_eligible),
        .last_grant_i (last_grant_q),
        .valid_o      (w_pick_valid),
        .grant_o      (w_pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_grant_d  = last_grant_q;
        ack_d         = '0;
        data_out_d    = data_out_q;
        ram_wr_en_d   = ram_wr_en_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;

        unique case (state_q)
            IDLE: begin
                ram_wr_en_d = 1'b0;
                if (w_pick_valid) begin
                    grant_idx_d   = w_pick_idx;
                    last_grant_d  = w_pick_idx;
                    ram_wr_en_d   = mem_if.wrEn[w_pick_idx];
                    ram_addr_d    = mem_if.addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_data_in_d = mem_if.dataIn[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                ram_wr_en_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                data_out_d         = mem_if.ramDataOut;
                ack_d[grant_idx_q] = 1'b1;
                state_d            = IDLE;
            end
            default: begin
                ram_wr_en_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            last_grant_q  <= IDX_WIDTH'(CORE_COUNT - 1);
            ack_q         <= '0;
            data_out_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_grant_q  <= last_grant_d;
            ack_q         <= ack_d;
            data_out_q    <= data_out_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign mem_if.ack       = ack_q;
    assign mem_if.dataOut   = data_out_q;
    assign mem_if.ramWrEn   = ram_wr_en_q;
    assign mem_if.ramAddr   = ram_addr_q;
    assign mem_if.ramDataIn = ram_data_in_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Scoreboard bench for mem_arbiter with a read-before-write RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int CORE_COUNT = 4;
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 8;

    typedef struct { int core; logic [11:0] data; } ack_exp_t;
    typedef struct { logic [7:0] a; logic [11:0] d; } wr_exp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_ack = -1;
    int exp_gap  = 0;

    ack_exp_t sb_q[$];
    wr_exp_t  ram_q[$];
    int       order_q[$];

    logic [11:0] ram [256];
    logic [11:0] rd_word;

    mem_arbiter_if #(
        .CORE_COUNT (CORE_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    mem_arbiter #(
        .CORE_COUNT (CORE_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Data RAM: registered read, old word returned on a write.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] = 12'h000;
            ram[8'h01] = 12'h0A1;
            ram[8'h02] = 12'h0A2;
            ram[8'h20] = 12'h111;
            for (int i = 0; i < 5; i++) ram[8'h40 + i] = 12'h400 + 12'(i);
        end
        rd_word = ram[bus.ramAddr];
        if (bus.ramWrEn === 1'b1) ram[bus.ramAddr] = bus.ramDataIn;
        bus.ramDataOut <= rd_word;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: RAM write port and ack/dataOut against the scoreboards.
    always @(negedge clk) begin : mon
        int idx;
        int found;
        if (bus.ramWrEn === 1'b1) begin
            if (ram_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ram_write: got addr %0h data %0h, expected none",
                         bus.ramAddr, bus.ramDataIn);
            end else begin
                chk("ram_write_addr", 32'(bus.ramAddr), 32'(ram_q[0].a));
                chk("ram_write_data", 32'(bus.ramDataIn), 32'(ram_q[0].d));
                void'(ram_q.pop_front());
            end
        end
        if ((|bus.ack) === 1'b1) begin
            idx = -1;
            for (int i = CORE_COUNT - 1; i >= 0; i--) if (bus.ack[i] === 1'b1) idx = i;
            chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
            found = -1;
            foreach (sb_q[k]) if (found < 0 && sb_q[k].core == idx) found = k;
            if (found < 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack %b, expected none", bus.ack);
            end else begin
                chk($sformatf("dataOut_core%0d", idx), 32'(bus.dataOut), 32'(sb_q[found].data));
                sb_q.delete(found);
            end
            if (order_q.size() > 0) chk("grant_order", idx, order_q.pop_front());
            if (exp_gap != 0 && last_ack >= 0) chk("ack_gap", cyc - last_ack, exp_gap);
            last_ack = cyc;
        end
    end

    // One core access; entered and left at one time unit after a rising edge.
    task automatic access(input int c, input bit we, input logic [7:0] a,
                          input logic [11:0] d, input logic [11:0] exp,
                          input int exp_lat, input bit late, input logic [7:0] late_a);
        int  n;
        bit  got;
        sb_q.push_back('{core: c, data: exp});
        if (we) ram_q.push_back('{a: a, d: d});
        bus.req[c]                   = 1'b1;
        bus.wrEn[c]                  = we;
        bus.addr[c*ADDR_WIDTH +: 8]  = a;
        bus.dataIn[c*DATA_WIDTH +: 12] = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            if (late && n == 1) begin
                #1;
                bus.addr[c*ADDR_WIDTH +: 8] = late_a;
            end
            @(negedge clk);
            if (bus.ack[c] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_core%0d: got no ack after %0d cycles, expected ack", c, n);
        end else if (exp_lat != 0) begin
            chk($sformatf("latency_core%0d", c), n, exp_lat);
        end
        @(posedge clk);
        #1;
        bus.req[c]  = 1'b0;
        bus.wrEn[c] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req    = '0;
        bus.wrEn   = '0;
        bus.addr   = '0;
        bus.dataIn = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",       32'(bus.ack),       32'h0);
        chk("rst_dataOut",   32'(bus.dataOut),   32'h0);
        chk("rst_ramWrEn",   32'(bus.ramWrEn),   32'h0);
        chk("rst_ramAddr",   32'(bus.ramAddr),   32'h0);
        chk("rst_ramDataIn", 32'(bus.ramDataIn), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write then read back from core 2.
        access(2, 1'b1, 8'h10, 12'hABC, 12'h000, 3, 1'b0, 8'h00);
        access(2, 1'b0, 8'h10, 12'h000, 12'hABC, 3, 1'b0, 8'h00);

        // All cores from reset: grants 0,1,2,3,0 three cycles apart.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_ack = -1;
        exp_gap  = 3;
        order_q  = '{0, 1, 2, 3, 0};
        fork
            begin
                access(0, 1'b0, 8'h40, 12'h000, 12'h400, 3, 1'b0, 8'h00);
                access(0, 1'b0, 8'h44, 12'h000, 12'h404, 11, 1'b0, 8'h00);
            end
            access(1, 1'b0, 8'h41, 12'h000, 12'h401, 6, 1'b0, 8'h00);
            access(2, 1'b0, 8'h42, 12'h000, 12'h402, 9, 1'b0, 8'h00);
            access(3, 1'b0, 8'h43, 12'h000, 12'h403, 12, 1'b0, 8'h00);
        join
        exp_gap = 0;

        // Write returns the previous word; read returns the new one.
        access(1, 1'b1, 8'h20, 12'h055, 12'h111, 3, 1'b0, 8'h00);
        access(1, 1'b0, 8'h20, 12'h000, 12'h055, 3, 1'b0, 8'h00);

        // Core 3 back-to-back with req held through the ack cycle.
        last_ack = -1;
        exp_gap  = 4;
        access(3, 1'b0, 8'h43, 12'h000, 12'h403, 3, 1'b0, 8'h00);
        access(3, 1'b0, 8'h42, 12'h000, 12'h402, 3, 1'b0, 8'h00);
        access(3, 1'b0, 8'h41, 12'h000, 12'h401, 3, 1'b0, 8'h00);
        exp_gap = 0;

        // Reset during the ISSUE cycle of a write: RAM still written, no ack.
        ram_q.push_back('{a: 8'h30, d: 12'h777});
        bus.req[1]          = 1'b1;
        bus.wrEn[1]         = 1'b1;
        bus.addr[8 +: 8]    = 8'h30;
        bus.dataIn[12 +: 12] = 12'h777;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.req[1]  = 1'b0;
        bus.wrEn[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ramWrEn", 32'(bus.ramWrEn), 32'h0);
        chk("post_rst_ack",     32'(bus.ack),     32'h0);
        chk("post_rst_ramAddr", 32'(bus.ramAddr), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        access(1, 1'b0, 8'h30, 12'h000, 12'h777, 3, 1'b0, 8'h00);

        // Address change during ISSUE must not affect the access.
        access(0, 1'b0, 8'h01, 12'h000, 12'h0A1, 3, 1'b1, 8'h02);

        repeat (6) @(posedge clk);
        chk("sb_drained",    sb_q.size(),    0);
        chk("ram_q_drained", ram_q.size(),   0);
        chk("order_drained", order_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
